// File: rtl/alien_drawer_if.sv
// Request and pixel-stream signals shared by the alien sprite drawer and its client.
// The master side issues redraw requests and consumes the VGA pixel stream.
interface alien_drawer_if;
    logic       go;
    logic [7:0] alien_x;
    logic [6:0] alien_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (output go, alien_x, alien_y,
                    input  vga_x, vga_y, colour, plot, busy, done);
    modport slave  (input  go, alien_x, alien_y,
                    output vga_x, vga_y, colour, plot, busy, done);
endinterface

// File: rtl/alien_drawer.sv
// Redraws a 4x4 masked sprite: erases the previous position in black, then draws the new one.
// One pixel per clock; pixels that fall off the 160x120 screen are suppressed but still counted.
module alien_drawer #(
    parameter logic [2:0]  COLOUR = 3'b010,
    parameter logic [15:0] MASK   = 16'b0110_1001_1111_0110
) (
    input  logic clk,
    input  logic resetn,
    alien_drawer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    state_t     state, nxt;
    logic [3:0] cnt;
    logic       old_valid;
    logic [7:0] old_x, new_x, base_x;
    logic [6:0] old_y, new_y, base_y;
    logic [8:0] px;
    logic [7:0] py;
    logic       on_screen;

    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot, busy, done;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= nxt;
    end

    // Widened sums: a sprite hanging off the right/bottom edge clips instead of wrapping.
    assign base_x    = (state == ERASE) ? old_x : new_x;
    assign base_y    = (state == ERASE) ? old_y : new_y;
    assign px        = {1'b0, base_x} + {7'd0, cnt[1:0]};
    assign py        = {1'b0, base_y} + {6'd0, cnt[3:2]};
    assign on_screen = (px <= 9'd159) && (py <= 8'd119);

    always_comb begin
        nxt    = state;
        plot   = 1'b0;
        vga_x  = 8'd0;
        vga_y  = 7'd0;
        colour = 3'b000;
        busy   = (state != IDLE);
        done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.go) nxt = old_valid ? ERASE : DRAW;
            end
            ERASE: begin
                plot  = on_screen;
                vga_x = px[7:0];
                vga_y = py[6:0];
                if (cnt == 4'd15) nxt = DRAW;
            end
            DRAW: begin
                plot   = on_screen;
                vga_x  = px[7:0];
                vga_y  = py[6:0];
                colour = MASK[cnt] ? COLOUR : 3'b000;
                if (cnt == 4'd15) nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= 4'd0;
            old_valid <= 1'b0;
            old_x     <= 8'd0;
            old_y     <= 7'd0;
            new_x     <= 8'd0;
            new_y     <= 7'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        new_x <= bus.alien_x;
                        new_y <= bus.alien_y;
                        cnt   <= 4'd0;
                    end
                end
                // Counter wraps 15->0, which also clears it between ERASE and DRAW.
                ERASE, DRAW: cnt <= cnt + 4'd1;
                DONE: begin
                    old_x     <= new_x;
                    old_y     <= new_y;
                    old_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.vga_x  = vga_x;
    assign bus.vga_y  = vga_y;
    assign bus.colour = colour;
    assign bus.plot   = plot;
    assign bus.busy   = busy;
    assign bus.done   = done;
endmodule

// File: tb/tb_alien_drawer.sv
// Directed bench for alien_drawer: first draw, erase+draw, clipping, ignored go, async abort, held go.
module tb_alien_drawer;
    logic clk;
    logic resetn;
    int   n_tot = 0;
    int   n_bad = 0;

    localparam logic [15:0] T_MASK = 16'b0110_1001_1111_0110;
    localparam logic [2:0]  T_COL  = 3'b010;

    alien_drawer_if ifc();

    alien_drawer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_tot++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s act=%0h req=%0h", tag, act, req);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_plot"}, 32'(ifc.plot), 32'd0);
        chk({tag, "_busy"}, 32'(ifc.busy), 32'd0);
        chk({tag, "_done"}, 32'(ifc.done), 32'd0);
        chk({tag, "_x"},    32'(ifc.vga_x), 32'd0);
        chk({tag, "_y"},    32'(ifc.vga_y), 32'd0);
        chk({tag, "_col"},  32'(ifc.colour), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn  = 1'b0;
        ifc.go  = 1'b0;
        @(negedge clk);
        chk_quiet("rst_in");
        resetn = 1'b1;
        @(negedge clk);
        chk_quiet("rst_out");
    endtask

    // One full redraw, checked pixel by pixel; optional go pulse + alien_x change mid-DRAW.
    task automatic redraw(input logic [7:0] x, input logic [6:0] y, input bit erase,
                          input logic [7:0] ox, input logic [6:0] oy, input bit poke,
                          output int plots);
        int         n, pi;
        bit         er;
        logic [3:0] c;
        logic [8:0] ex;
        logic [7:0] ey;
        bit         vis;
        logic [2:0] ecol;
        logic [15:0] m;
        m     = T_MASK;
        plots = 0;
        n     = erase ? 32 : 16;
        pi    = erase ? 21 : 5;
        @(negedge clk);
        ifc.go = 1'b1; ifc.alien_x = x; ifc.alien_y = y;
        @(negedge clk);
        ifc.go = 1'b0;
        for (int i = 0; i < n; i++) begin
            er   = erase && (i < 16);
            c    = 4'(i % 16);
            ex   = er ? ({1'b0, ox} + 9'(c[1:0])) : ({1'b0, x} + 9'(c[1:0]));
            ey   = er ? ({1'b0, oy} + 8'(c[3:2])) : ({1'b0, y} + 8'(c[3:2]));
            vis  = (ex <= 9'd159) && (ey <= 8'd119);
            ecol = er ? 3'b000 : (m[c] ? T_COL : 3'b000);
            chk("busy", 32'(ifc.busy), 32'd1);
            chk("done_early", 32'(ifc.done), 32'd0);
            chk("plot", 32'(ifc.plot), 32'(vis));
            if (ifc.plot) plots++;
            if (vis) begin
                chk("vga_x", 32'(ifc.vga_x), 32'(ex));
                chk("vga_y", 32'(ifc.vga_y), 32'(ey));
                chk("colour", 32'(ifc.colour), 32'(ecol));
            end
            if (poke && i == pi) begin
                ifc.go = 1'b1; ifc.alien_x = x ^ 8'h55;
            end
            if (poke && i == pi + 1) ifc.go = 1'b0;
            @(negedge clk);
        end
        chk("done_pulse", 32'(ifc.done), 32'd1);
        chk("done_busy", 32'(ifc.busy), 32'd1);
        chk("done_plot", 32'(ifc.plot), 32'd0);
        @(negedge clk);
        chk_quiet("idle");
        if (poke) begin
            @(negedge clk);
            chk("no_requeue_busy", 32'(ifc.busy), 32'd0);
            chk("no_requeue_done", 32'(ifc.done), 32'd0);
        end
    endtask

    initial begin
        int plots;
        int ph;
        int waitc;
        resetn = 1'b0; ifc.go = 1'b0; ifc.alien_x = 8'd0; ifc.alien_y = 7'd0;
        #2;
        chk("async_rst_plot", 32'(ifc.plot), 32'd0);
        chk("async_rst_busy", 32'(ifc.busy), 32'd0);
        do_reset();

        // First draw: no erase, 16 plotted pixels.
        redraw(8'd50, 7'd15, 1'b0, 8'd0, 7'd0, 1'b0, plots);
        chk("first_plots", 32'(plots), 32'd16);

        // Second draw: erase (50,15) then draw (51,15).
        redraw(8'd51, 7'd15, 1'b1, 8'd50, 7'd15, 1'b0, plots);
        chk("second_plots", 32'(plots), 32'd32);

        // Clipping at the bottom-right corner on a first draw.
        do_reset();
        redraw(8'd158, 7'd118, 1'b0, 8'd0, 7'd0, 1'b0, plots);
        chk("clip_plots", 32'(plots), 32'd4);

        // Clipped erase, then go pulse + alien_x change during DRAW is ignored.
        redraw(8'd20, 7'd30, 1'b1, 8'd158, 7'd118, 1'b1, plots);
        chk("poke_plots", 32'(plots), 32'd20);

        // Async reset at cnt=7 of ERASE.
        @(negedge clk);
        ifc.go = 1'b1; ifc.alien_x = 8'd70; ifc.alien_y = 7'd40;
        @(negedge clk);
        ifc.go = 1'b0;
        for (int i = 0; i < 7; i++) @(negedge clk);
        chk("pre_abort_plot", 32'(ifc.plot), 32'd1);
        chk("pre_abort_x", 32'(ifc.vga_x), 32'd23);
        chk("pre_abort_y", 32'(ifc.vga_y), 32'd31);
        #2 resetn = 1'b0;
        #1;
        chk_quiet("abort");
        @(negedge clk);
        resetn = 1'b1;
        redraw(8'd60, 7'd20, 1'b0, 8'd0, 7'd0, 1'b0, plots);
        chk("after_abort_plots", 32'(plots), 32'd16);

        // go held high: ERASE16 + DRAW16 + DONE + IDLE repeating.
        @(negedge clk);
        ifc.go = 1'b1; ifc.alien_x = 8'd60; ifc.alien_y = 7'd20;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            ph = k % 34;
            chk("hold_busy", 32'(ifc.busy), (ph == 33) ? 32'd0 : 32'd1);
            chk("hold_done", 32'(ifc.done), (ph == 32) ? 32'd1 : 32'd0);
            chk("hold_plot", 32'(ifc.plot), (ph < 32) ? 32'd1 : 32'd0);
            if (ph < 32) chk("hold_x", 32'(ifc.vga_x), 32'(60 + (ph % 4)));
        end
        ifc.go = 1'b0;
        waitc = 0;
        while (ifc.busy && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        chk("hold_drain", 32'(ifc.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
